// File: rtl/hs_ram_arbiter.sv
// ---------------------------------------------------------------------------
// hs_ram_arbiter
//
// Shares the game core's work-RAM port between the running CPU and the
// hiscore save/restore engine. When the hiscore side raises hs_req the
// arbiter pauses the core. It waits for the CPU bus to stay quiet for SETTLE
// consecutive cycles, or gives up after TIMEOUT cycles and forces the grant.
// It then hands the RAM port to the hiscore side. When hs_req drops, one
// guard cycle returns the mux to the CPU with writes blocked before the core
// is released.
//
// Parameters
//   AW       RAM address width
//   DW       RAM data width
//   SETTLE   consecutive cpu_idle cycles required before grant (1..255)
//   TIMEOUT  max cycles spent pausing before a forced grant (SETTLE..65535)
//
// Ports
//   clk_sys       system clock
//   reset_n       asynchronous active-low reset
//   hs_req        hiscore wants the RAM (level)
//   hs_addr       hiscore address
//   hs_wdata      hiscore write data
//   hs_we         hiscore write strobe
//   hs_rdata      registered read data back to hiscore
//   hs_rvalid     hs_rdata was updated at the last clock edge
//   hs_grant      hiscore currently owns the RAM port
//   pause_req     active-high pause request to the core
//   cpu_idle      core reports no bus cycle in progress
//   cpu_addr      CPU address
//   cpu_wdata     CPU write data
//   cpu_we        CPU write strobe
//   ram_addr      address to RAM
//   ram_wdata     write data to RAM
//   ram_we        write strobe to RAM
//   ram_rdata     RAM read data (one-cycle synchronous latency)
//   timeout_flag  sticky: a forced grant has occurred since reset
// ---------------------------------------------------------------------------
module hs_ram_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic          clk_sys,
   input  logic          reset_n,

   input  logic          hs_req,
   input  logic [AW-1:0] hs_addr,
   input  logic [DW-1:0] hs_wdata,
   input  logic          hs_we,
   output logic [DW-1:0] hs_rdata,
   output logic          hs_rvalid,
   output logic          hs_grant,

   output logic          pause_req,
   input  logic          cpu_idle,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_we,

   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata,

   output logic          timeout_flag
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAUSING,
      ST_GRANT,
      ST_RELEASE
   } state_t;

   localparam logic [7:0]  SETTLE_CNT  = 8'(SETTLE);
   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t      state;
   state_t      state_next;

   logic [7:0]  settle_cnt;
   logic [15:0] timeout_cnt;
   logic        settle_done;
   logic        timeout_done;
   logic        start_pause;

   // The grant decisions compare the registered counts. The cycle in which a
   // count reaches its limit is therefore still spent pausing, which gives
   // the SETTLE+1 minimum latency from leaving IDLE to owning the port.
   assign settle_done  = (settle_cnt  >= SETTLE_CNT);
   assign timeout_done = (timeout_cnt >= TIMEOUT_CNT);
   assign start_pause  = (state == ST_IDLE) && hs_req;

   // State register. An asynchronous reset drops straight back to IDLE, so
   // the mux returns to the CPU and the pause is released without any guard
   // cycle.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. While pausing, a dropped request is checked before
   // either grant condition, so an abort always beats a grant in the same
   // cycle. RELEASE always passes through IDLE, which rules out a
   // back-to-back grant.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (hs_req) begin
               state_next = ST_PAUSING;
            end
         end
         ST_PAUSING: begin
            if (!hs_req) begin
               state_next = ST_RELEASE;
            end else if (settle_done || timeout_done) begin
               state_next = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!hs_req) begin
               state_next = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Output decode. The pause stays asserted through RELEASE, so the core
   // only restarts once the RAM mux is already back on the CPU side.
   always_comb begin
      pause_req = 1'b0;
      hs_grant  = 1'b0;
      case (state)
         ST_PAUSING: begin
            pause_req = 1'b1;
         end
         ST_GRANT: begin
            pause_req = 1'b1;
            hs_grant  = 1'b1;
         end
         ST_RELEASE: begin
            pause_req = 1'b1;
         end
         default: begin
            pause_req = 1'b0;
            hs_grant  = 1'b0;
         end
      endcase
   end

   // RAM port mux. Only one side's write strobe can ever reach the RAM. In
   // GRANT the CPU strobe is gated off. Everywhere else the hiscore strobe is
   // ignored. The RELEASE cycle forces ram_we low so that a CPU write already
   // pending on the bus cannot land on the cycle the mux switches back.
   always_comb begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
      if (state == ST_GRANT) begin
         ram_addr  = hs_addr;
         ram_wdata = hs_wdata;
         ram_we    = hs_we;
      end else if (state == ST_RELEASE) begin
         ram_we    = 1'b0;
      end
   end

   // Settle and timeout counters. Both restart from zero on entry to
   // PAUSING. The settle count restarts whenever the CPU shows bus activity,
   // so only an unbroken run of idle cycles can lead to a grant. Both
   // counters saturate, so they cannot wrap back below their limits.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         settle_cnt  <= '0;
         timeout_cnt <= '0;
      end else if (start_pause) begin
         settle_cnt  <= '0;
         timeout_cnt <= '0;
      end else if (state == ST_PAUSING) begin
         if (!cpu_idle) begin
            settle_cnt <= '0;
         end else if (settle_cnt != 8'hFF) begin
            settle_cnt <= settle_cnt + 8'd1;
         end
         if (timeout_cnt != 16'hFFFF) begin
            timeout_cnt <= timeout_cnt + 16'd1;
         end
      end
   end

   // Sticky timeout flag. It is set only when the grant is forced by the
   // timeout: the request must still be up, and the settle condition must
   // not have been met at the same time. It is cleared only by reset.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         timeout_flag <= 1'b0;
      end else if ((state == ST_PAUSING) && hs_req && timeout_done && !settle_done) begin
         timeout_flag <= 1'b1;
      end
   end

   // Read return path. While granted, every RAM read word is captured.
   // hs_rvalid marks the cycles in which hs_rdata holds a freshly captured
   // word. Together with the RAM's own latency, an address presented in
   // cycle N returns its data in cycle N+2. Outside GRANT the last captured
   // word is held.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hs_rdata  <= '0;
         hs_rvalid <= 1'b0;
      end else begin
         hs_rvalid <= (state == ST_GRANT);
         if (state == ST_GRANT) begin
            hs_rdata <= ram_rdata;
         end
      end
   end

endmodule
